// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring round-robin arbiter: FSM encodings and
// one-hot helpers sized for up to MAXN requesters.
package ring_arb_pkg;

  localparam int MAXN = 64;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef logic [MAXN-1:0] vec_t;

  // One-hot to binary; OR of set-bit indices, exact for one-hot input.
  function automatic int unsigned oh2bin(input vec_t v);
    int unsigned b;
    b = 0;
    for (int i = 0; i < MAXN; i++)
      if (v[i]) b = b | unsigned'(i);
    return b;
  endfunction

  // Rotate left by one within the low n bits.
  function automatic vec_t rotl1(input vec_t v, input int n);
    vec_t r;
    vec_t mask;
    mask = (vec_t'(1) << n) - vec_t'(1);
    r    = (v << 1) | (v >> (n - 1));
    return r & mask;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requester agents and the ring arbiter.
interface ring_rr_arbiter_if #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [HW-1:0] hold_cnt;

  modport master (
    output req,
    input  grant, grant_valid, grant_idx, hold_cnt
  );

  modport slave (
    input  req,
    output grant, grant_valid, grant_idx, hold_cnt
  );
endinterface

// File: rtl/ring_ptr.sv
// One-hot ring pointer; reset to bit 0, loads the position after the owner.
module ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] owner,
  output logic [N-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset)     ptr <= N'(1);
    else if (load) ptr <= N'(rotl1(vec_t'(owner), N));
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with one-hot ring priority and a per-grant burst limit.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int HW       = $clog2(MAX_HOLD + 1),
  localparam int IW       = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  ring_rr_arbiter_if.slave bus
);

  logic [0:0]   state;
  logic [N-1:0] ptr;
  logic [N-1:0] rot;
  logic [N-1:0] arb_ptr;
  logic [N-1:0] masked;
  logic [N-1:0] winner;
  logic         keep;
  logic         rel;

  assign keep = (state == BUSY) && (|(bus.req & bus.grant))
              && (bus.hold_cnt < HW'(MAX_HOLD));
  assign rel  = (state == BUSY) && !keep;

  // On release the departing owner drops to lowest priority in this same edge.
  assign rot     = N'(rotl1(vec_t'(bus.grant), N));
  assign arb_ptr = rel ? rot : ptr;

  // Circular first-set from arb_ptr: try bits at/above the pointer, else wrap.
  always_comb begin
    masked = bus.req & ~(arb_ptr - N'(1));
    winner = '0;
    if (|masked) winner = masked & (~masked + N'(1));
    else         winner = bus.req & (~bus.req + N'(1));
  end

  ring_ptr #(.N(N)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .load  (rel),
    .owner (bus.grant),
    .ptr   (ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.grant       <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_idx   <= '0;
      bus.hold_cnt    <= '0;
    end else if (keep) begin
      bus.hold_cnt <= bus.hold_cnt + HW'(1);
    end else begin
      state           <= (|winner) ? BUSY : IDLE;
      bus.grant       <= winner;
      bus.grant_valid <= |winner;
      bus.grant_idx   <= IW'(oh2bin(vec_t'(winner)));
      bus.hold_cnt    <= (|winner) ? HW'(1) : '0;
    end
  end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among N requesters. A one-hot ring pointer sets the circular priority order. Each grant is held while the owner keeps requesting, up to a burst limit. It sits between requester agents and the shared datapath and drives its one-hot select.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted (>= 1)
HW, $clog2(MAX_HOLD+1), hold counter width (derived, not overridden)
IW, $clog2(N), grant index width (derived)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on clk rising edge
req  input  N  request vector; bit i = requester i wants the resource
grant  output  N  registered one-hot grant; all-zero when idle
grant_valid  output  1  registered; high whenever grant is non-zero
grant_idx  output  IW  registered binary index of the granted requester; 0 when idle
hold_cnt  output  HW  registered count of cycles the current grant has been asserted; 0 when idle

Behaviour:
- Reset, sampled at an edge with reset=1: grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, state=IDLE, ring pointer ptr=one-hot bit 0.
- Reset mid-grant: the grant drops at that same edge. No pointer rotation is credited.
- States: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit in circular order starting at the ptr position (ptr, ptr+1, ..., wrapping at N-1 to 0).
  - At the next edge: grant=winner, hold_cnt=1, go to BUSY.
  - Latency is one cycle, req sampled to grant visible.
- BUSY, evaluated each edge with owner = current grant:
  - Keep the grant if req[owner]=1 and hold_cnt<MAX_HOLD. In that case hold_cnt increments.
  - Release if req[owner]=0 or hold_cnt==MAX_HOLD. Both conditions on the same edge count as a single release.
  - On release, ptr loads rotate-left(owner), i.e. one-hot at owner+1 mod N.
  - Re-arbitration happens in the same edge using the new ptr and the current req.
  - If a winner exists, grant switches directly to it with hold_cnt=1. There is no idle bubble and no cycle with two grant bits set.
  - If no winner exists, go to IDLE with grant=0 and hold_cnt=0.
- Owner is lowest priority after release. If the owner is the only requester at MAX_HOLD, it is re-granted continuously: grant stays high and hold_cnt restarts at 1.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - grant_idx encodes grant.
  - hold_cnt is never greater than MAX_HOLD.
- Requests for non-owner bits may toggle freely during BUSY and never affect the current grant.

Decomposition:
- Shared package (ring_arb_pkg, or a `include file if the codebase stays in Verilog-2001) holds:
  - state encodings IDLE=1'b0, BUSY=1'b1
  - the one-hot-to-binary function
  - the rotate-left-by-one function
- One natural sub-module: ring_ptr, an N-bit one-hot ring register with synchronous active-high reset to bit 0 and a load enable taking rotate-left(owner).
- The circular priority picker stays combinational inside ring_rr_arbiter.

Test Plan:
1. Reset 2 cycles with req=1111 -> grant=0000, grant_valid=0, grant_idx=0, hold_cnt=0 throughout reset. The first grant after release of reset is 0001.
2. N=4: req=0100 for 3 cycles, then 0000 -> grant=0100 from cycle after first sample, hold_cnt 1,2,3. grant=0000 one cycle after req drops. A following req=1111 is granted 1000 (ptr rotated).
3. req=1111 constant, MAX_HOLD=8 -> grant sequence 0001,0010,0100,1000,0001, each exactly 8 cycles, switch with no zero cycle, grant_idx 0,1,2,3,0.
4. Wrap: owner 1000 releases with req=0011 -> next grant 0001 (wrap to bit 0), then 0010 after it releases.
5. Lone owner: req=0001 held 20 cycles -> grant=0001 continuously. hold_cnt runs 1..8 then restarts at 1. grant_valid never drops.
6. Reset asserted while grant=0010 at hold_cnt=3 -> grant=0000 at that edge. After reset release with req=0110, grant=0010 (ptr back at bit 0).
